// File: rtl/soc_bus_pkg.sv
// Shared definitions for the native memory bus: widths, strobes, DMA FSM states
// and a small address helper. Also used by the RAM/IO responders.
package soc_bus_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = 4;
  localparam int WORD_BYTES = 4;

  localparam logic [STRB_W-1:0] WSTRB_ALL  = 4'b1111;
  localparam logic [STRB_W-1:0] WSTRB_NONE = 4'b0000;

  // Copy sequencer states; each REQ state is followed by a one-cycle gap so
  // responders always see a fresh rising edge of mem_valid.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_GAP,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_FIN,
    ST_ABORT
  } dma_state_t;

  // Clear the byte offset so every access is word aligned.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/native_bus_xact.sv
// Single-transaction initiator for the native memory bus. While req is high the
// request is presented on mem_*; ack marks the mem_ready cycle, tout marks the
// last cycle the request may wait before the owner abandons it. The read word is
// captured only in the ready cycle and held for the following write.
module native_bus_xact
  import soc_bus_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ack,
  output logic              tout,
  output logic [DATA_W-1:0] rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0]     tcnt_reg;
  logic [DATA_W-1:0] rdata_reg;

  // Bus outputs are zero whenever no request is outstanding.
  always_comb begin
    mem_valid = req;
    mem_instr = 1'b0;
    mem_addr  = req ? addr : '0;
    mem_wdata = (req && write) ? wdata : '0;
    mem_wstrb = (req && write) ? WSTRB_ALL : WSTRB_NONE;
    ack       = req && mem_ready;
    // tcnt_reg counts cycles already spent waiting, so this fires in the
    // TIMEOUT-th cycle of mem_valid and the request drops right after it.
    tout      = req && !mem_ready && (tcnt_reg == TW'(TIMEOUT - 1));
    rdata     = rdata_reg;
  end

  // Wait-cycle counter restarts for every new request.
  always_ff @(posedge clk) begin
    if (reset || !req || mem_ready) begin
      tcnt_reg <= '0;
    end else begin
      tcnt_reg <= tcnt_reg + 1'b1;
    end
  end

  // Capture read data only in the completing cycle of a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (ack && !write) begin
      rdata_reg <= mem_rdata;
    end
  end

endmodule

// File: rtl/mem_dma_master.sv
// Word-copy DMA engine on the native memory bus. A start pulse in IDLE samples
// source, destination and length; words are then read and written one at a
// time, with a single idle cycle after every transfer.
module mem_dma_master
  import soc_bus_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cfg_src,
  input  logic [31:0]       cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_done,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  dma_state_t        state_reg, state_next;
  logic [31:0]       src_ptr_reg, src_ptr_next;
  logic [31:0]       dst_ptr_reg, dst_ptr_next;
  logic [LEN_W-1:0]  remaining_reg, remaining_next;
  logic [LEN_W-1:0]  words_done_reg, words_done_next;
  logic              error_reg, error_next;

  logic              xact_req;
  logic              xact_write;
  logic [31:0]       xact_addr;
  logic              xact_ack;
  logic              xact_tout;
  logic [31:0]       xact_rdata;

  native_bus_xact #(
    .TIMEOUT (TIMEOUT)
  ) u_xact (
    .clk       (clk),
    .reset     (reset),
    .req       (xact_req),
    .write     (xact_write),
    .addr      (xact_addr),
    .wdata     (xact_rdata),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ack       (xact_ack),
    .tout      (xact_tout),
    .rdata     (xact_rdata)
  );

  // Sequencer: next state, pointer/count updates and status outputs.
  always_comb begin
    state_next      = state_reg;
    src_ptr_next    = src_ptr_reg;
    dst_ptr_next    = dst_ptr_reg;
    remaining_next  = remaining_reg;
    words_done_next = words_done_reg;
    error_next      = error_reg;
    xact_req        = 1'b0;
    xact_write      = 1'b0;
    xact_addr       = src_ptr_reg;
    busy            = 1'b0;
    done            = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          src_ptr_next    = word_align(cfg_src);
          dst_ptr_next    = word_align(cfg_dst);
          remaining_next  = cfg_len;
          words_done_next = '0;
          error_next      = 1'b0;
          // A zero-length copy still reports completion, without bus traffic.
          state_next      = (cfg_len == '0) ? ST_FIN : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        busy     = 1'b1;
        xact_req = 1'b1;
        if (xact_ack) begin
          src_ptr_next = src_ptr_reg + 32'(WORD_BYTES);
          state_next   = ST_RD_GAP;
        end else if (xact_tout) begin
          error_next = 1'b1;
          state_next = ST_ABORT;
        end
      end
      ST_RD_GAP: begin
        busy       = 1'b1;
        state_next = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        busy       = 1'b1;
        xact_req   = 1'b1;
        xact_write = 1'b1;
        xact_addr  = dst_ptr_reg;
        if (xact_ack) begin
          dst_ptr_next    = dst_ptr_reg + 32'(WORD_BYTES);
          remaining_next  = remaining_reg - 1'b1;
          words_done_next = words_done_reg + 1'b1;
          state_next      = ST_WR_GAP;
        end else if (xact_tout) begin
          error_next = 1'b1;
          state_next = ST_ABORT;
        end
      end
      ST_WR_GAP: begin
        busy       = 1'b1;
        state_next = (remaining_reg != '0) ? ST_RD_REQ : ST_FIN;
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ABORT: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset always wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      src_ptr_reg    <= '0;
      dst_ptr_reg    <= '0;
      remaining_reg  <= '0;
      words_done_reg <= '0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      src_ptr_reg    <= src_ptr_next;
      dst_ptr_reg    <= dst_ptr_next;
      remaining_reg  <= remaining_next;
      words_done_reg <= words_done_next;
      error_reg      <= error_next;
    end
  end

  assign error      = error_reg;
  assign words_done = words_done_reg;

endmodule
